// File: rtl/sized_data_memory_pkg.sv
// Shared definitions for the sized data memory: access size codes, controller
// states and the access legality check.
package sized_data_memory_pkg;

  localparam logic [1:0] SIZE_BYTE    = 2'b00;
  localparam logic [1:0] SIZE_HALF    = 2'b01;
  localparam logic [1:0] SIZE_WORD    = 2'b10;
  localparam logic [1:0] SIZE_ILLEGAL = 2'b11;

  typedef enum logic {
    ST_INIT,
    ST_IDLE
  } state_e;

  // Misaligned, illegal size, or beyond the 4*2**depth_log2 byte window.
  function automatic logic access_fault(input logic [1:0]  size,
                                        input logic [31:0] addr,
                                        input int unsigned depth_log2);
    logic bad_align;
    case (size)
      SIZE_BYTE: bad_align = 1'b0;
      SIZE_HALF: bad_align = addr[0];
      SIZE_WORD: bad_align = |addr[1:0];
      default:   bad_align = 1'b1;
    endcase
    return bad_align | ((addr >> (depth_log2 + 2)) != 32'd0);
  endfunction

endpackage

// File: rtl/sized_data_memory_align.sv
// Byte-lane steering: extracts and extends load data from a raw word, and
// builds the byte enables and lane-positioned data for stores.
module sized_data_memory_align
  import sized_data_memory_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [1:0]         size,
  input  logic               zero_ext,
  input  logic [1:0]         lane,
  input  logic [WIDTH-1:0]   rword,
  input  logic [WIDTH-1:0]   wdata,
  output logic [WIDTH-1:0]   load_data,
  output logic [WIDTH/8-1:0] byte_en,
  output logic [WIDTH-1:0]   store_data
);

  localparam int NB = WIDTH / 8;

  logic [WIDTH-1:0] shifted;

  always_comb begin
    shifted    = rword >> {lane, 3'b000};
    store_data = wdata << {lane, 3'b000};
    load_data  = '0;
    byte_en    = '0;
    case (size)
      SIZE_BYTE: begin
        load_data = {{(WIDTH-8){~zero_ext & shifted[7]}}, shifted[7:0]};
        byte_en   = {{(NB-1){1'b0}}, 1'b1} << lane;
      end
      SIZE_HALF: begin
        load_data = {{(WIDTH-16){~zero_ext & shifted[15]}}, shifted[15:0]};
        byte_en   = {{(NB-2){1'b0}}, 2'b11} << lane;
      end
      SIZE_WORD: begin
        load_data = rword;
        byte_en   = '1;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/sized_data_memory.sv
// Byte/half/word addressable data memory with self-zeroing after reset and a
// fixed one-cycle load response; faults are reported instead of accessing.
module sized_data_memory
  import sized_data_memory_pkg::*;
#(
  parameter int WIDTH      = 32,
  parameter int DEPTH_LOG2 = 10
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_req,
  input  logic             i_we,
  input  logic [1:0]       i_size,
  input  logic             i_unsigned,
  input  logic [31:0]      i_address,
  input  logic [WIDTH-1:0] i_data,
  output logic             o_ready,
  output logic             o_valid,
  output logic [WIDTH-1:0] o_data,
  output logic             o_fault
);

  localparam int NB = WIDTH / 8;

  logic [WIDTH-1:0]      mem [2**DEPTH_LOG2];
  state_e                state;
  logic [DEPTH_LOG2-1:0] init_idx;
  logic                  ready_q;
  logic                  valid_q;
  logic                  fault_q;
  logic [WIDTH-1:0]      data_q;

  logic [DEPTH_LOG2-1:0] widx;
  logic                  accept;
  logic                  fault;
  logic [WIDTH-1:0]      load_data;
  logic [NB-1:0]         byte_en;
  logic [WIDTH-1:0]      store_data;

  assign widx   = i_address[DEPTH_LOG2+1:2];
  assign accept = i_req & ready_q & (state == ST_IDLE) & ~i_rst;
  assign fault  = access_fault(i_size, i_address, DEPTH_LOG2);

  sized_data_memory_align #(.WIDTH(WIDTH)) u_align (
    .size       (i_size),
    .zero_ext   (i_unsigned),
    .lane       (i_address[1:0]),
    .rword      (mem[widx]),
    .wdata      (i_data),
    .load_data  (load_data),
    .byte_en    (byte_en),
    .store_data (store_data)
  );

  // Storage carries no reset; INIT sweeps it to zero instead.
  always_ff @(posedge i_clk) begin
    if (!i_rst && state == ST_INIT) begin
      mem[init_idx] <= '0;
    end else if (accept && i_we && !fault) begin
      for (int b = 0; b < NB; b++)
        if (byte_en[b]) mem[widx][b*8 +: 8] <= store_data[b*8 +: 8];
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state    <= ST_INIT;
      init_idx <= '0;
      ready_q  <= 1'b0;
      valid_q  <= 1'b0;
      fault_q  <= 1'b0;
      data_q   <= '0;
    end else begin
      valid_q <= 1'b0;
      fault_q <= 1'b0;
      data_q  <= '0;
      case (state)
        ST_INIT: begin
          init_idx <= init_idx + 1'b1;
          if (init_idx == '1) begin
            state   <= ST_IDLE;
            ready_q <= 1'b1;
          end
        end
        ST_IDLE: begin
          // Loads always respond; stores respond only when they fault.
          valid_q <= accept & (~i_we | fault);
          fault_q <= accept & fault;
          if (accept && !i_we && !fault) data_q <= load_data;
        end
        default: state <= ST_INIT;
      endcase
    end
  end

  // A reset arriving while a response is on the bus squashes it immediately.
  assign o_ready = ready_q & ~i_rst;
  assign o_valid = valid_q & ~i_rst;
  assign o_fault = fault_q & ~i_rst;
  assign o_data  = i_rst ? '0 : data_q;

endmodule
